// File: rtl/ibex_rf_wb_stage.sv
// rtl/ibex_rf_wb_stage.sv - writeback merge of EX and LSU writes with skid buffer and read forwarding
module ibex_rf_wb_stage #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,

  input  logic                 ex_we_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,

  input  logic                 lsu_we_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,

  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,

  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_a_o,
  output logic                 fwd_b_o,
  output logic [DataWidth-1:0] fwd_data_a_o,
  output logic [DataWidth-1:0] fwd_data_b_o,

  output logic                 err_o
);

  typedef enum logic {BufEmpty, BufFull} buf_state_e;

  buf_state_e           buf_state_q, buf_state_d;
  logic [4:0]           buf_addr_q, buf_addr_d;
  logic [DataWidth-1:0] buf_data_q, buf_data_d;
  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
  logic                 err_q, err_d;
  logic                 ex_we_q;

  logic buf_full, ex_take, ex_ok, lsu_ok;

  // x0 writes are silently dropped; on RV32E x16..x31 are dropped as well
  function automatic logic addr_legal(input logic [4:0] addr);
    return (addr != 5'd0) && !(RV32E && addr[4]);
  endfunction

  function automatic logic addr_illegal(input logic [4:0] addr);
    return RV32E && addr[4];
  endfunction

  // Buffer first (youngest), then output stage, then the EX write being accepted now
  function automatic logic [DataWidth:0] fwd_lookup(
    input logic [4:0]           raddr,
    input logic                 b_valid,
    input logic [4:0]           b_addr,
    input logic [DataWidth-1:0] b_data,
    input logic                 o_we,
    input logic [4:0]           o_addr,
    input logic [DataWidth-1:0] o_data,
    input logic                 e_ok,
    input logic [4:0]           e_addr,
    input logic [DataWidth-1:0] e_data
  );
    if (raddr == 5'd0)                  return {1'b0, WordZeroVal};
    else if (b_valid && b_addr == raddr) return {1'b1, b_data};
    else if (o_we && o_addr == raddr)    return {1'b1, o_data};
    else if (e_ok && e_addr == raddr)    return {1'b1, e_data};
    else                                 return {1'b0, WordZeroVal};
  endfunction

  assign buf_full   = (buf_state_q == BufFull);
  assign ex_take    = ex_we_i & ~buf_full;
  assign ex_ok      = ex_take & addr_legal(ex_waddr_i);
  assign lsu_ok     = lsu_we_i & addr_legal(lsu_waddr_i);
  assign ex_ready_o = ~buf_full;

  // Pick this cycle's RF write (LSU > buffered EX > new EX) and next buffer contents
  always_comb begin
    buf_state_d = buf_state_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    if (lsu_ok) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = lsu_waddr_i;
      rf_wdata_d = lsu_wdata_i;
      if (ex_ok) begin
        buf_state_d = BufFull;
        buf_addr_d  = ex_waddr_i;
        buf_data_d  = ex_wdata_i;
      end
    end else if (buf_full) begin
      rf_we_d     = 1'b1;
      rf_waddr_d  = buf_addr_q;
      rf_wdata_d  = buf_data_q;
      buf_state_d = BufEmpty;
    end else if (ex_ok) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = ex_waddr_i;
      rf_wdata_d = ex_wdata_i;
    end
    err_d = (lsu_we_i & addr_illegal(lsu_waddr_i))
          | (ex_take & addr_illegal(ex_waddr_i))
          | (ex_we_i & ~ex_we_q & buf_full);
  end

  // Stage registers; reset discards any buffered or pending write
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_state_q <= BufEmpty;
      buf_addr_q  <= 5'd0;
      buf_data_q  <= WordZeroVal;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 5'd0;
      rf_wdata_q  <= WordZeroVal;
      err_q       <= 1'b0;
      ex_we_q     <= 1'b0;
    end else begin
      buf_state_q <= buf_state_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      err_q       <= err_d;
      ex_we_q     <= ex_we_i;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign err_o      = err_q;

  assign {fwd_a_o, fwd_data_a_o} = fwd_lookup(raddr_a_i, buf_full, buf_addr_q, buf_data_q,
                                              rf_we_q, rf_waddr_q, rf_wdata_q,
                                              ex_ok, ex_waddr_i, ex_wdata_i);
  assign {fwd_b_o, fwd_data_b_o} = fwd_lookup(raddr_b_i, buf_full, buf_addr_q, buf_data_q,
                                              rf_we_q, rf_waddr_q, rf_wdata_q,
                                              ex_ok, ex_waddr_i, ex_wdata_i);

endmodule

// File: tb/tb_ibex_rf_wb_stage.sv
// tb/tb_ibex_rf_wb_stage.sv - randomized self-checking bench for ibex_rf_wb_stage
module tb_ibex_rf_wb_stage;

  logic        clk_int = 1'b0;
  logic        rst_ni;
  logic        ex_we_i, lsu_we_i;
  logic [4:0]  ex_waddr_i, lsu_waddr_i, raddr_a_i, raddr_b_i;
  logic [31:0] ex_wdata_i, lsu_wdata_i;
  logic        ex_ready_o, rf_we_o, fwd_a_o, fwd_b_o, err_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o, fwd_data_a_o, fwd_data_b_o;

  always #5 clk_int = ~clk_int;

  ibex_rf_wb_stage #(
    .RV32E      (1'b1),
    .DataWidth  (32),
    .WordZeroVal(32'h0)
  ) dut (
    .clk_int     (clk_int),
    .rst_ni      (rst_ni),
    .ex_we_i     (ex_we_i),
    .ex_waddr_i  (ex_waddr_i),
    .ex_wdata_i  (ex_wdata_i),
    .ex_ready_o  (ex_ready_o),
    .lsu_we_i    (lsu_we_i),
    .lsu_waddr_i (lsu_waddr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .raddr_a_i   (raddr_a_i),
    .raddr_b_i   (raddr_b_i),
    .fwd_a_o     (fwd_a_o),
    .fwd_b_o     (fwd_b_o),
    .fwd_data_a_o(fwd_data_a_o),
    .fwd_data_b_o(fwd_data_b_o),
    .err_o       (err_o)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  // Reference model: writes waiting to issue (program order), and last issued write
  wr_t         m_wait[$];
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_prev_ex;
  logic [31:0] gold [32];
  logic [31:0] seen [32];

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [4:0] a);
    return (a != 5'd0) && (a < 5'd16);
  endfunction

  function automatic logic [32:0] m_fwd(input logic [4:0] ra, input bit ex_acc, input wr_t exw);
    if (ra == 5'd0) return 33'h0;
    if (m_wait.size() > 0 && m_wait[0].a == ra) return {1'b1, m_wait[0].d};
    if (m_we && m_addr == ra) return {1'b1, m_data};
    if (ex_acc && exw.a == ra) return {1'b1, exw.d};
    return 33'h0;
  endfunction

  task automatic model_reset();
    m_wait.delete();
    m_we      = 1'b0;
    m_addr    = 5'd0;
    m_data    = 32'h0;
    m_prev_ex = 1'b0;
  endtask

  task automatic idle_inputs();
    ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    lsu_we_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
    raddr_a_i = 0; raddr_b_i = 0;
  endtask

  // Async reset applied now; outputs must clear without waiting for a clock
  task automatic apply_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_val("rst_ex_ready", ex_ready_o, 1);
    check_val("rst_rf_we", rf_we_o, 0);
    check_val("rst_rf_waddr", rf_waddr_o, 0);
    check_val("rst_rf_wdata", rf_wdata_o, 0);
    check_val("rst_err", err_o, 0);
    repeat (2) @(posedge clk_int);
    @(negedge clk_int);
    rst_ni = 1'b1;
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered ones
  task automatic step(input bit lw, input logic [4:0] la, input logic [31:0] ld,
                      input bit ew, input logic [4:0] ea, input logic [31:0] ed,
                      input logic [4:0] ra, input logic [4:0] rb, output bit acc);
    wr_t cand[$];
    wr_t exw, lsw, e;
    logic [32:0] fa, fb;
    bit rdy, ex_acc, exp_err;
    @(negedge clk_int);
    lsu_we_i = lw; lsu_waddr_i = la; lsu_wdata_i = ld;
    ex_we_i = ew; ex_waddr_i = ea; ex_wdata_i = ed;
    raddr_a_i = ra; raddr_b_i = rb;
    #1;
    exw.a = ea; exw.d = ed;
    lsw.a = la; lsw.d = ld;
    rdy    = (m_wait.size() == 0);
    acc    = ew && rdy;
    ex_acc = acc && legal(ea);
    fa = m_fwd(ra, ex_acc, exw);
    fb = m_fwd(rb, ex_acc, exw);
    check_val("ex_ready", ex_ready_o, rdy);
    check_val("fwd_a", fwd_a_o, fa[32]);
    check_val("fwd_data_a", fwd_data_a_o, fa[31:0]);
    check_val("fwd_b", fwd_b_o, fb[32]);
    check_val("fwd_data_b", fwd_data_b_o, fb[31:0]);
    exp_err = (lw && la >= 5'd16) || (ew && rdy && ea >= 5'd16) || (ew && !m_prev_ex && !rdy);
    if (lw && legal(la)) cand.push_back(lsw);
    foreach (m_wait[i]) cand.push_back(m_wait[i]);
    if (ex_acc) cand.push_back(exw);
    @(posedge clk_int);
    #1;
    if (cand.size() > 0) begin
      e = cand.pop_front();
      m_we = 1'b1; m_addr = e.a; m_data = e.d;
      gold[e.a] = e.d;
    end else begin
      m_we = 1'b0;
    end
    m_wait    = cand;
    m_prev_ex = ew;
    if (rf_we_o) seen[rf_waddr_o] = rf_wdata_o;
    check_val("rf_we", rf_we_o, m_we);
    check_val("rf_waddr", rf_waddr_o, m_addr);
    check_val("rf_wdata", rf_wdata_o, m_data);
    check_val("err", err_o, exp_err);
  endtask

  initial begin
    bit acc;
    bit ex_pend;
    logic [4:0]  ex_a;
    logic [31:0] ex_d;
    for (int i = 0; i < 32; i++) begin
      gold[i] = 32'h0;
      seen[i] = 32'h0;
    end
    apply_reset();

    // Plain EX write
    step(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, acc);
    check_val("tp1_waddr", rf_waddr_o, 5);
    check_val("tp1_wdata", rf_wdata_o, 32'hDEADBEEF);
    check_val("tp1_ready", ex_ready_o, 1);

    // Collision: LSU first, buffered EX next
    step(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, acc);
    check_val("tp2_first", rf_waddr_o, 3);
    check_val("tp2_ready_lo", ex_ready_o, 0);
    step(0, 0, 0, 0, 0, 0, 4, 3, acc);
    check_val("tp2_second", rf_waddr_o, 4);
    check_val("tp2_ready_hi", ex_ready_o, 1);

    // Collision followed by another LSU: order x3, x7, x4
    step(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, acc);
    step(1, 7, 32'h33, 0, 0, 0, 4, 7, acc);
    check_val("tp3_mid", rf_waddr_o, 7);
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    check_val("tp3_last", rf_waddr_o, 4);

    // Buffer beats output stage for the same register; x0 never forwards
    step(1, 4, 32'h99, 1, 4, 32'h22, 0, 0, acc);
    raddr_a_i = 4; raddr_b_i = 0;
    #1;
    check_val("tp4_fwd_a", fwd_a_o, 1);
    check_val("tp4_fwd_data_a", fwd_data_a_o, 32'h22);
    check_val("tp4_fwd_b", fwd_b_o, 0);
    step(0, 0, 0, 0, 0, 0, 4, 0, acc);

    // x0 dropped silently, x20 dropped with err
    step(0, 0, 0, 1, 0, 32'h55, 0, 0, acc);
    check_val("tp5_x0_we", rf_we_o, 0);
    check_val("tp5_x0_err", err_o, 0);
    step(0, 0, 0, 1, 20, 32'h66, 20, 0, acc);
    check_val("tp5_x20_we", rf_we_o, 0);
    check_val("tp5_x20_err", err_o, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    check_val("tp5_err_pulse", err_o, 0);

    // EX newly raised while FULL: err, not captured
    step(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, acc);
    step(1, 6, 32'h44, 0, 0, 0, 0, 0, acc);
    step(0, 0, 0, 1, 9, 32'h77, 9, 0, acc);
    check_val("ovf_err", err_o, 1);
    check_val("ovf_drain", rf_waddr_o, 4);
    step(0, 0, 0, 0, 0, 0, 9, 0, acc);
    check_val("ovf_dropped", rf_we_o, 0);

    // Reset while FULL
    step(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, acc);
    apply_reset();
    step(0, 0, 0, 0, 0, 0, 4, 0, acc);
    check_val("rst_no_stale", rf_we_o, 0);

    // Randomized traffic with a handshake-respecting EX driver
    ex_pend = 0; ex_a = 0; ex_d = 0;
    for (int i = 0; i < 400; i++) begin
      bit lw;
      logic [4:0] la;
      if (!ex_pend && m_wait.size() == 0 && ($urandom % 2 == 1)) begin
        ex_pend = 1;
        ex_a = ($urandom % 8 == 0) ? 5'($urandom % 32) : 5'($urandom % 16);
        ex_d = $urandom;
      end
      lw = ($urandom % 3 == 0);
      la = ($urandom % 10 == 0) ? 5'($urandom % 32) : 5'($urandom % 16);
      step(lw, la, $urandom, ex_pend, ex_a, ex_d, 5'($urandom % 16), 5'($urandom % 16), acc);
      if (acc) ex_pend = 0;
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    for (int i = 1; i < 16; i++) check_val("rf_final", seen[i], gold[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
